seq_signed_divider_8_bit: RTL and testbench

- Iterative signed N-bit divider: the inverse operation of the team's combinational Wallace-tree multiplier.
- Computes quotient and remainder of X_in / Y_in using restoring division, one quotient bit per clock.
- Start/done handshake, fixed latency.
- Sits beside the multiplier in the lab datapath. Results must satisfy X = Q*Y + R, so multiplier output can be fed back for cross-checking.

---
 rtl/seq_signed_divider_8_bit.sv | 121 ++++++++++++
 tb/tb_seq_signed_divider_8_bit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider_8_bit.sv
// Iterative signed restoring divider: one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor skips CALC and completes one edge after start.
module seq_signed_divider_8_bit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] X_in,
  input  logic [N-1:0] Y_in,
  output logic [N-1:0] Q_out,
  output logic [N-1:0] R_out,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [N:0]    rem;
  logic [N-1:0]  dvd;
  logic [N-1:0]  abs_y;
  logic [N-1:0]  x_raw;
  logic          sign_x;
  logic          sign_y;
  logic          y_zero;
  logic          ov_pend;

  logic [N-1:0]  abs_x_in;
  logic [N-1:0]  abs_y_in;
  logic [N:0]    rem_sh;
  logic [N:0]    diff;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  always_comb begin
    abs_x_in = X_in[N-1] ? -X_in : X_in;
    abs_y_in = Y_in[N-1] ? -Y_in : Y_in;
    // rem < abs_y before the shift, so diff always lies within the (N+1)-bit signed range
    rem_sh   = {rem[N-1:0], dvd[N-1]};
    diff     = rem_sh - {1'b0, abs_y};
    q_fix    = (sign_x ^ sign_y) ? -dvd : dvd;
    r_fix    = sign_x ? -rem[N-1:0] : rem[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      abs_y       <= '0;
      x_raw       <= '0;
      sign_x      <= 1'b0;
      sign_y      <= 1'b0;
      y_zero      <= 1'b0;
      ov_pend     <= 1'b0;
      Q_out       <= '0;
      R_out       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_x  <= X_in[N-1];
            sign_y  <= Y_in[N-1];
            dvd     <= abs_x_in;
            abs_y   <= abs_y_in;
            x_raw   <= X_in;
            y_zero  <= (Y_in == '0);
            ov_pend <= (X_in == {1'b1, {(N-1){1'b0}}}) && (Y_in == '1);
            rem     <= '0;
            count   <= CW'(N - 1);
            busy    <= 1'b1;
            state   <= CALC;
`ifdef DIV_ZERO_FASTPATH_EN
            if (Y_in == '0) state <= FIX;
`endif
          end
        end
        CALC: begin
          rem   <= diff[N] ? rem_sh : diff;
          dvd   <= {dvd[N-2:0], ~diff[N]};
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          if (y_zero) begin
            Q_out       <= '1;
            R_out       <= x_raw;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            Q_out       <= q_fix;
            R_out       <= r_fix;
            div_by_zero <= 1'b0;
            overflow    <= ov_pend;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider_8_bit.sv
// Bench for seq_signed_divider_8_bit: cycle-level reference model plus directed literal vectors.
module tb_seq_signed_divider_8_bit;

  localparam int N = 8;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] X_in = '0;
  logic [N-1:0] Y_in = '0;
  logic [N-1:0] Q_out, R_out;
  logic         busy, done, div_by_zero, overflow;

  seq_signed_divider_8_bit #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .X_in(X_in), .Y_in(Y_in),
    .Q_out(Q_out), .R_out(R_out), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  // Reference arithmetic: SV signed / and % plus the two special cases
  function automatic void ref_div(input int x, input int y, output logic [N-1:0] q,
                                  output logic [N-1:0] r, output bit dz, output bit ov);
    int qi, ri;
    dz = 1'b0; ov = 1'b0;
    if (y == 0) begin
      qi = -1; ri = x; dz = 1'b1;
    end else if (x == -(1 << (N-1)) && y == -1) begin
      qi = -(1 << (N-1)); ri = 0; ov = 1'b1;
    end else begin
      qi = x / y; ri = x % y;
    end
    q = qi[N-1:0];
    r = ri[N-1:0];
  endfunction

  // Cycle model: operation accepted when idle, completes after a fixed number of edges
  bit           m_busy = 0, m_done = 0, m_dz = 0, m_ov = 0, p_dz, p_ov;
  logic [N-1:0] m_q = '0, m_r = '0, p_q, p_r;
  int           m_left = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_ov = 0; m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
        end
      end else if (start) begin
        ref_div(int'($signed(X_in)), int'($signed(Y_in)), p_q, p_r, p_dz, p_ov);
        m_busy = 1;
        m_left = (FAST && Y_in == '0) ? 1 : N + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (done !== m_done || busy !== m_busy || Q_out !== m_q || R_out !== m_r ||
          div_by_zero !== m_dz || overflow !== m_ov) begin
        n_err++;
        $display("FAIL model cyc=%0d: got done=%b busy=%b Q=%h R=%h dz=%b ov=%b, required done=%b busy=%b Q=%h R=%h dz=%b ov=%b",
                 cyc, done, busy, Q_out, R_out, div_by_zero, overflow,
                 m_done, m_busy, m_q, m_r, m_dz, m_ov);
        if (n_err > 25) begin
          $display("FAIL abort: too many miscompares");
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
          $finish;
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input int x, input int y, output int lat);
    @(negedge clk);
    X_in = x[N-1:0]; Y_in = y[N-1:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X_in = N'($urandom); Y_in = N'($urandom);
    wait_done(lat);
  endtask

  function automatic int exp_lat(input int y);
    return (FAST && y == 0) ? 1 : N + 1;
  endfunction

  typedef struct { int x; int y; int q; int r; int dz; int ov; } vec_t;
  vec_t vecs[12] = '{
    '{100, 7, 14, 2, 0, 0},     '{-100, 7, -14, -2, 0, 0},
    '{100, -7, -14, 2, 0, 0},   '{-100, -7, 14, -2, 0, 0},
    '{-128, -1, -128, 0, 0, 1}, '{5, 0, -1, 5, 1, 0},
    '{-128, 1, -128, 0, 0, 0},  '{127, -128, 0, 127, 0, 0},
    '{-128, -128, 1, 0, 0, 0},  '{-7, 0, -1, -7, 1, 0},
    '{0, 5, 0, 0, 0, 0},        '{7, 7, 1, 0, 0, 0}
  };
  int js[14] = '{-128, -127, -100, -9, -3, -2, -1, 1, 2, 3, 5, 13, 64, 127};

  initial begin
    int lat, seen, last, bad;
    int bx[20], by[20];
    logic [N-1:0] eq, er;
    bit edz, eov;

    repeat (2) @(posedge clk);
    #1;
    check("reset Q", int'(Q_out), 0);
    check("reset R", int'(R_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset flags", int'({div_by_zero, overflow}), 0);
    chk_en = 1'b1;
    @(negedge clk) reset_n = 1'b1;

    foreach (vecs[v]) begin
      do_op(vecs[v].x, vecs[v].y, lat);
      check($sformatf("lat %0d/%0d", vecs[v].x, vecs[v].y), lat, exp_lat(vecs[v].y));
      check($sformatf("Q %0d/%0d", vecs[v].x, vecs[v].y), int'($signed(Q_out)), vecs[v].q);
      check($sformatf("R %0d/%0d", vecs[v].x, vecs[v].y), int'($signed(R_out)), vecs[v].r);
      check($sformatf("dz %0d/%0d", vecs[v].x, vecs[v].y), int'(div_by_zero), vecs[v].dz);
      check($sformatf("ov %0d/%0d", vecs[v].x, vecs[v].y), int'(overflow), vecs[v].ov);
      check("busy at done", int'(busy), 0);
    end

    // abort during the 4th CALC cycle
    @(negedge clk);
    X_in = 8'd50; Y_in = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort Q", int'(Q_out), 0);
    check("abort R", int'(R_out), 0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no done after abort", seen, 0);
    do_op(50, 3, lat);
    check("Q 50/3", int'($signed(Q_out)), 16);
    check("R 50/3", int'($signed(R_out)), 2);

    // start raised while busy must be ignored
    @(negedge clk);
    X_in = 8'd50; Y_in = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    X_in = 8'd1; Y_in = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    check("busy-start lat", lat + 3, N + 1);
    check("busy-start Q", int'($signed(Q_out)), 16);
    check("busy-start R", int'($signed(R_out)), 2);
    seen = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("ignored start made no op", seen, 0);

    // sampled sweep, stop at first mismatch
    bad = 0;
    for (int i = -128; i <= 127 && !bad; i += 9) begin
      foreach (js[k]) begin
        if (!(i == -128 && js[k] == -1)) begin
          do_op(i, js[k], lat);
          if (int'($signed(Q_out)) != i / js[k] || int'($signed(R_out)) != i % js[k] || lat != N + 1) begin
            n_vec++; n_err++; bad = 1;
            $display("FAIL sweep %0d/%0d: got Q=%0d R=%0d lat=%0d, required Q=%0d R=%0d lat=%0d",
                     i, js[k], $signed(Q_out), $signed(R_out), lat, i / js[k], i % js[k], N + 1);
            break;
          end
          n_vec++;
        end
      end
    end

    // back-to-back: start in every done cycle
    foreach (bx[t]) begin
      bx[t] = int'($urandom_range(0, 255)) - 128;
      by[t] = int'($urandom_range(0, 255)) - 128;
      if (by[t] == 0) by[t] = 1;
    end
    @(negedge clk);
    X_in = bx[0][N-1:0]; Y_in = by[0][N-1:0]; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    last = 0;
    for (int t = 0; t < 20; t++) begin
      wait_done(lat);
      check("b2b done seen", int'(done), 1);
      ref_div(bx[t], by[t], eq, er, edz, eov);
      check($sformatf("b2b Q %0d/%0d", bx[t], by[t]), int'(Q_out), int'(eq));
      check($sformatf("b2b R %0d/%0d", bx[t], by[t]), int'(R_out), int'(er));
      if (t > 0) check("b2b period", cyc - last, N + 2);
      last = cyc;
      if (t < 19) begin
        X_in = bx[t+1][N-1:0]; Y_in = by[t+1][N-1:0]; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
